// File: rtl/bht_predictor_pkg.sv
// Shared definitions for the branch history table predictor:
// 2-bit counter encodings and the default table index width.
package bht_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam int BHT_INDEX_W_DEF = 6;

endpackage

// File: rtl/bht_sat_update.sv
// Next-state function of one 2-bit saturating branch counter.
// Taken moves toward ST, not-taken toward SNT; both ends saturate.
module bht_sat_update
    import bht_predictor_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic       taken_i,
    output logic [1:0] state_o
);

    // Saturating increment/decrement of the counter
    always_comb begin
        state_o = state_i;
        case (state_i)
            SNT: begin
                if (taken_i) state_o = WNT;
                else         state_o = SNT;
            end
            WNT: begin
                if (taken_i) state_o = WT;
                else         state_o = SNT;
            end
            WT: begin
                if (taken_i) state_o = ST;
                else         state_o = WNT;
            end
            ST: begin
                if (taken_i) state_o = ST;
                else         state_o = WT;
            end
            default: state_o = state_i;
        endcase
    end

endmodule

// File: rtl/bht_predictor.sv
// Untagged 2-bit bimodal branch predictor with EX-stage training.
// Optional resolved/mispredict statistics enabled by macro BHT_STATS_EN.
module bht_predictor
    import bht_predictor_pkg::*;
#(
    parameter int         INDEX_W    = BHT_INDEX_W_DEF,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    input  logic        btb_hit_IF,
    output logic        pred_taken_IF,
    input  logic        upd_valid_EX,
    input  logic [31:0] PC_EX,
    input  logic        taken_EX,
    input  logic        pred_taken_EX,
    output logic        mispredict_EX,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic [1:0]         tbl_q [ENTRIES];
    logic [INDEX_W-1:0] rd_idx_s;
    logic [INDEX_W-1:0] upd_idx_s;
    logic [1:0]         upd_cur_s;
    logic [1:0]         tbl_upd_d;
    logic               unused_pc_s;

    assign rd_idx_s    = PC_IF[INDEX_W+1:2];
    assign upd_idx_s   = PC_EX[INDEX_W+1:2];
    assign upd_cur_s   = tbl_q[upd_idx_s];
    assign unused_pc_s = ^{PC_IF[31:INDEX_W+2], PC_IF[1:0],
                           PC_EX[31:INDEX_W+2], PC_EX[1:0]};

    // Read straight from the table: a same-cycle update is not bypassed
    assign pred_taken_IF = btb_hit_IF & tbl_q[rd_idx_s][1];
    assign mispredict_EX = upd_valid_EX & (taken_EX ^ pred_taken_EX);

    bht_sat_update u_sat_update (
        .state_i (upd_cur_s),
        .taken_i (taken_EX),
        .state_o (tbl_upd_d)
    );

    // Counter table: reset to INIT_STATE, otherwise train the resolving entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= INIT_STATE;
            end
        end else if (upd_valid_EX) begin
            tbl_q[upd_idx_s] <= tbl_upd_d;
        end else begin
            tbl_q[upd_idx_s] <= upd_cur_s;
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] br_count_d;
    logic [31:0] mispred_count_q;
    logic [31:0] mispred_count_d;

    // Statistics next-state; both counters wrap modulo 2^32
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_valid_EX) begin
            br_count_d = br_count_q + 32'd1;
        end else begin
            br_count_d = br_count_q;
        end
        if (mispredict_EX) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end else begin
            mispred_count_d = mispred_count_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`else
    assign br_count      = 32'h0;
    assign mispred_count = 32'h0;
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Directed, table-driven bench for bht_predictor (default INDEX_W=6, INIT_STATE=01).
// Statistics expectations follow whether BHT_STATS_EN is defined.
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_IF;
    logic        btb_hit_IF;
    logic        pred_taken_IF;
    logic        upd_valid_EX;
    logic [31:0] PC_EX;
    logic        taken_EX;
    logic        pred_taken_EX;
    logic        mispredict_EX;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bht_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .PC_IF         (PC_IF),
        .btb_hit_IF    (btb_hit_IF),
        .pred_taken_IF (pred_taken_IF),
        .upd_valid_EX  (upd_valid_EX),
        .PC_EX         (PC_EX),
        .taken_EX      (taken_EX),
        .pred_taken_EX (pred_taken_EX),
        .mispredict_EX (mispredict_EX),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    typedef struct {
        logic [31:0] pc_if;
        logic        btb;
        logic        upd;
        logic [31:0] pc_ex;
        logic        taken;
        logic        pred_ex;
        logic        rst;
        logic        exp_pred;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pcif, input logic btb,
                         input logic upd, input logic [31:0] pcex, input logic tk,
                         input logic pex);
        rst           = r;
        PC_IF         = pcif;
        btb_hit_IF    = btb;
        upd_valid_EX  = upd;
        PC_EX         = pcex;
        taken_EX      = tk;
        pred_taken_EX = pex;
    endtask

    initial begin
        logic [31:0] exp_br;
        logic [31:0] exp_mc;

        //            pc_if       btb   upd   pc_ex       tk    pex   rst   pred  mis
        vecs[0]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h100, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h104, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h104, 1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h104, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h104, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // one taken from saturated 00 must give 01, still predicting not-taken
        vecs[12] = '{32'h104, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{32'h104, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h108, 1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{32'h108, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{32'h208, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        // reset with a concurrent taken update of 0x10C: update must be dropped
        vecs[17] = '{32'h108, 1'b1, 1'b1, 32'h10C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{32'h108, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{32'h10C, 1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("reset_pred", {31'd0, pred_taken_IF}, 32'd0);
        chk("reset_br_count", br_count, 32'd0);
        chk("reset_mispred_count", mispred_count, 32'd0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 17) begin
`ifdef BHT_STATS_EN
                exp_br = 32'd10;
                exp_mc = 32'd5;
`else
                exp_br = 32'd0;
                exp_mc = 32'd0;
`endif
                chk("pre_reset_br_count", br_count, exp_br);
                chk("pre_reset_mispred_count", mispred_count, exp_mc);
            end
            drive(vecs[i].rst, vecs[i].pc_if, vecs[i].btb, vecs[i].upd,
                  vecs[i].pc_ex, vecs[i].taken, vecs[i].pred_ex);
            #1;
            chk($sformatf("vec%0d_pred", i), {31'd0, pred_taken_IF}, {31'd0, vecs[i].exp_pred});
            chk($sformatf("vec%0d_mispred", i), {31'd0, mispredict_EX}, {31'd0, vecs[i].exp_mis});
        end

        @(negedge clk);
        chk("post_reset_br_count", br_count, 32'd0);
        chk("post_reset_mispred_count", mispred_count, 32'd0);

        // ten taken updates across distinct entries; the first three were predicted not-taken
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200 + 32'(i * 4), 1'b1, (i < 3) ? 1'b0 : 1'b1);
            #1;
            chk($sformatf("stats%0d_mispred", i), {31'd0, mispredict_EX},
                {31'd0, (i < 3) ? 1'b1 : 1'b0});
            @(negedge clk);
        end
        drive(1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("idle_no_mispred", {31'd0, mispredict_EX}, 32'd0);
        chk("stats_entry_trained", {31'd0, pred_taken_IF}, 32'd1);
`ifdef BHT_STATS_EN
        exp_br = 32'd10;
        exp_mc = 32'd3;
`else
        exp_br = 32'd0;
        exp_mc = 32'd0;
`endif
        chk("final_br_count", br_count, exp_br);
        chk("final_mispred_count", mispred_count, exp_mc);

        // idle cycle must not move the statistics
        @(negedge clk);
        chk("idle_br_count", br_count, exp_br);
        chk("idle_mispred_count", mispred_count, exp_mc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
